alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Operand issue stage that drives the EXU ALU's operand, opcode and bubble inputs.
- Takes decoded instruction fields and register-file read data from ID and selects each operand (register, PC, immediate or zero).
- Resolves RAW hazards by forwarding from the EXU and WB results, and detects load-use hazards, answering them with a one-cycle bubble plus an upstream stall.
- Outputs are registered; this block is the producer side of the ALU operand interface.

Parameters:
- XLEN, 32, datapath width; matches the core XLEN macro.
- RADDR_W, 5, register address width.

Ports:
- clk  input  1  clock
- aresetn  input  1  asynchronous reset, active-low
- i_stall  input  1  downstream stall; holds all output registers
- i_bubble  input  1  ID slot is empty/invalid
- i_opcode  input  4  ALU opcode, ALU_* encoding
- i_rs0_addr  input  RADDR_W  source-0 register address
- i_rs1_addr  input  RADDR_W  source-1 register address
- i_rs0_data  input  XLEN  register-file read data, source 0
- i_rs1_data  input  XLEN  register-file read data, source 1
- i_pc  input  XLEN  instruction PC
- i_imm  input  XLEN  sign-extended immediate
- i_op0_sel  input  2  operand-0 select, op0_sel_t: RS0=0, PC=1, ZERO=2
- i_op1_sel  input  1  operand-1 select, op1_sel_t: RS1=0, IMM=1
- i_rdt_addr  input  RADDR_W  destination register
- i_rdt_en  input  1  instruction writes rd
- i_is_load  input  1  instruction is a load
- i_exu_data  input  XLEN  EXU result, one stage ahead
- i_wb_rdt_addr  input  RADDR_W  WB destination register
- i_wb_rdt_en  input  1  WB write enable
- i_wb_data  input  XLEN  WB write data
- o_op0  output  XLEN  ALU operand 0
- o_op1  output  XLEN  ALU operand 1
- o_opcode  output  4  ALU opcode
- o_bubble  output  1  ALU bubble in
- o_rdt_addr  output  RADDR_W  in-flight destination register
- o_rdt_en  output  1  in-flight write enable (0 when bubble)
- o_stall_up  output  1  stall request to ID/IF

Behaviour:
- Reset (asynchronous, aresetn=0):
  - o_bubble=1; all other outputs 0.
  - Hazard FSM returns to RUN.
  - Reset mid-hazard aborts the hazard; no stall persists after release.
- Latency: one clock from an accepted ID slot to the registered outputs.
- Internal tracking registers: ex_rdt_addr, ex_rdt_en and ex_is_load, describing the instruction currently issued to the ALU. They update under the same enable as the outputs.
- Forwarding, per source register s (rs0 or rs1), in priority order:
  1. s==0: value is 0; no forwarding.
  2. ex_rdt_en && ex_rdt_addr==s && !ex_is_load: value is i_exu_data.
  3. i_wb_rdt_en && i_wb_rdt_addr==s: value is i_wb_data.
  4. Otherwise: value is the register-file data.
- Operand select:
  - op0: RS0 gives forwarded rs0; PC gives i_pc; ZERO gives 0; code 3 gives 0 and marks the slot as a bubble.
  - op1: RS1 gives forwarded rs1; IMM gives i_imm.
  - A source is "used" only when its select is RS0/RS1.
- Load-use hazard: load_use = !i_bubble && ex_rdt_en && ex_is_load && ex_rdt_addr!=0 && a used source equals ex_rdt_addr.
- FSM:
  - RUN: on load_use && !i_stall, issue a bubble (o_bubble=1, o_rdt_en=0), assert o_stall_up, go to HOLD. Otherwise issue the ID slot normally.
  - HOLD: exactly one cycle, o_stall_up=0. By now the load is in WB and the held ID slot re-evaluates with WB forwarding. Return to RUN and issue normally, or take a new load_use (back-to-back loads).
- Stall: i_stall=1 freezes all output and tracking registers and the FSM state, and drives o_stall_up=1 combinationally.
- o_stall_up = i_stall | (state==RUN && load_use).
- i_bubble=1 issues a bubble. o_op0/o_op1/o_opcode still load (don't-care), and o_rdt_en=0.
- A bubble never forwards and never triggers a hazard.

Decomposition:
- pqr5_core_pkg gains:
  - op0_sel_t and op1_sel_t enums.
  - issue_state_t {RUN, HOLD}.
  - Reuse of the existing ALU_* opcode constants.
- One sub-module, opnd_fwd_mux: a combinational forwarding mux instantiated twice (rs0, rs1). Inputs: address, regfile data, EXU and WB tap fields. Output: resolved value.

Test Plan:
- Reset release, then ADD x3=x1+x2 with i_rs0_data=5, i_rs1_data=7, no forwarding -> next cycle o_op0=5, o_op1=7, o_opcode=ALU_ADD, o_bubble=0, o_rdt_addr=3.
- ALU producer x5 followed by consumer rs0=x5, i_exu_data=0x10, i_wb writing x5=0x99 -> o_op0=0x10 (EXU forward wins over WB).
- Load to x6, then ADDI using rs0=x6:
  - Cycle 1: o_bubble=1 and o_stall_up=1.
  - Next cycle, with WB x6=0x1234: o_op0=0x1234, o_bubble=0, o_stall_up=0.
- rs0=x0 while EXU and WB both target x0 with data 0xFFFF_FFFF -> o_op0=0.
- i_stall=1 held for 3 cycles while ID inputs change -> outputs unchanged and o_stall_up=1 throughout; on release the current ID slot issues.
- Assert aresetn=0 during HOLD -> o_bubble=1, outputs 0, o_stall_up=0. After release the first instruction issues with no residual stall.

Source files
------------

// File: rtl/pqr5_core_pkg.sv
// pqr5 core shared types: ALU opcodes, operand selects and issue-stage state.
`default_nettype none

package pqr5_core_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    typedef enum logic [1:0] {
        OP0_RS0  = 2'd0,
        OP0_PC   = 2'd1,
        OP0_ZERO = 2'd2
    } op0_sel_t;

    typedef enum logic {
        OP1_RS1 = 1'b0,
        OP1_IMM = 1'b1
    } op1_sel_t;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } issue_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_issue_opnd_fwd_mux.sv
// opnd_fwd_mux: resolves one source register against the EXU and WB result taps.
`default_nettype none

module opnd_fwd_mux #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] addr,
    input  logic [XLEN-1:0]    rf_data,
    input  logic [RADDR_W-1:0] ex_rdt_addr,
    input  logic               ex_rdt_en,
    input  logic               ex_is_load,
    input  logic [XLEN-1:0]    exu_data,
    input  logic [RADDR_W-1:0] wb_rdt_addr,
    input  logic               wb_rdt_en,
    input  logic [XLEN-1:0]    wb_data,
    output logic [XLEN-1:0]    value
);

    // A load in EX has no data yet; the hazard logic stalls instead of forwarding it.
    always_comb begin
        if (addr == '0) begin
            value = '0;
        end else if (ex_rdt_en && (ex_rdt_addr == addr) && !ex_is_load) begin
            value = exu_data;
        end else if (wb_rdt_en && (wb_rdt_addr == addr)) begin
            value = wb_data;
        end else begin
            value = rf_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue.sv
// alu_issue: registered ALU operand issue stage with forwarding and load-use bubbling.
`default_nettype none

module alu_issue
    import pqr5_core_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               aresetn,
    input  logic               i_stall,
    input  logic               i_bubble,
    input  logic [3:0]         i_opcode,
    input  logic [RADDR_W-1:0] i_rs0_addr,
    input  logic [RADDR_W-1:0] i_rs1_addr,
    input  logic [XLEN-1:0]    i_rs0_data,
    input  logic [XLEN-1:0]    i_rs1_data,
    input  logic [XLEN-1:0]    i_pc,
    input  logic [XLEN-1:0]    i_imm,
    input  logic [1:0]         i_op0_sel,
    input  logic               i_op1_sel,
    input  logic [RADDR_W-1:0] i_rdt_addr,
    input  logic               i_rdt_en,
    input  logic               i_is_load,
    input  logic [XLEN-1:0]    i_exu_data,
    input  logic [RADDR_W-1:0] i_wb_rdt_addr,
    input  logic               i_wb_rdt_en,
    input  logic [XLEN-1:0]    i_wb_data,
    output logic [XLEN-1:0]    o_op0,
    output logic [XLEN-1:0]    o_op1,
    output logic [3:0]         o_opcode,
    output logic               o_bubble,
    output logic [RADDR_W-1:0] o_rdt_addr,
    output logic               o_rdt_en,
    output logic               o_stall_up
);

    issue_state_t       state;
    issue_state_t       state_nxt;
    logic [XLEN-1:0]    rs0_fwd;
    logic [XLEN-1:0]    rs1_fwd;
    logic [XLEN-1:0]    op0_val;
    logic [XLEN-1:0]    op1_val;
    logic [RADDR_W-1:0] ex_rdt_addr;
    logic               ex_rdt_en;
    logic               ex_is_load;
    logic               use0;
    logic               use1;
    logic               sel_bad;
    logic               slot_bubble;
    logic               load_use;
    logic               issue_bubble;

    opnd_fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs0 (
        .addr        (i_rs0_addr),
        .rf_data     (i_rs0_data),
        .ex_rdt_addr (ex_rdt_addr),
        .ex_rdt_en   (ex_rdt_en),
        .ex_is_load  (ex_is_load),
        .exu_data    (i_exu_data),
        .wb_rdt_addr (i_wb_rdt_addr),
        .wb_rdt_en   (i_wb_rdt_en),
        .wb_data     (i_wb_data),
        .value       (rs0_fwd)
    );

    opnd_fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
        .addr        (i_rs1_addr),
        .rf_data     (i_rs1_data),
        .ex_rdt_addr (ex_rdt_addr),
        .ex_rdt_en   (ex_rdt_en),
        .ex_is_load  (ex_is_load),
        .exu_data    (i_exu_data),
        .wb_rdt_addr (i_wb_rdt_addr),
        .wb_rdt_en   (i_wb_rdt_en),
        .wb_data     (i_wb_data),
        .value       (rs1_fwd)
    );

    always_comb begin
        op0_val = '0;
        sel_bad = 1'b0;
        case (i_op0_sel)
            OP0_RS0:  op0_val = rs0_fwd;
            OP0_PC:   op0_val = i_pc;
            OP0_ZERO: op0_val = '0;
            default:  sel_bad = 1'b1;
        endcase
        op1_val = (i_op1_sel == OP1_IMM) ? i_imm : rs1_fwd;
    end

    assign use0        = (i_op0_sel == OP0_RS0);
    assign use1        = (i_op1_sel == OP1_RS1);
    assign slot_bubble = i_bubble | sel_bad;

    assign load_use = !slot_bubble && ex_rdt_en && ex_is_load && (ex_rdt_addr != '0)
                      && ((use0 && (i_rs0_addr == ex_rdt_addr))
                       || (use1 && (i_rs1_addr == ex_rdt_addr)));

    // HOLD lasts one cycle: the load has reached WB, so the held slot re-issues via WB forwarding.
    always_comb begin
        state_nxt    = state;
        issue_bubble = slot_bubble;
        case (state)
            RUN: begin
                if (load_use) begin
                    issue_bubble = 1'b1;
                    state_nxt    = HOLD;
                end
            end
            HOLD:    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign o_stall_up = i_stall | ((state == RUN) && load_use);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= RUN;
            o_op0       <= '0;
            o_op1       <= '0;
            o_opcode    <= '0;
            o_bubble    <= 1'b1;
            ex_rdt_addr <= '0;
            ex_rdt_en   <= 1'b0;
            ex_is_load  <= 1'b0;
        end else if (!i_stall) begin
            state       <= state_nxt;
            o_op0       <= op0_val;
            o_op1       <= op1_val;
            o_opcode    <= i_opcode;
            o_bubble    <= issue_bubble;
            ex_rdt_addr <= i_rdt_addr;
            ex_rdt_en   <= i_rdt_en & ~issue_bubble;
            ex_is_load  <= i_is_load & ~issue_bubble;
        end
    end

    assign o_rdt_addr = ex_rdt_addr;
    assign o_rdt_en   = ex_rdt_en;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue.
`default_nettype none

module tb_alu_issue;
    import pqr5_core_pkg::*;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        i_stall, i_bubble;
    logic [3:0]  i_opcode;
    logic [4:0]  i_rs0_addr, i_rs1_addr, i_rdt_addr, i_wb_rdt_addr;
    logic [31:0] i_rs0_data, i_rs1_data, i_pc, i_imm, i_exu_data, i_wb_data;
    logic [1:0]  i_op0_sel;
    logic        i_op1_sel, i_rdt_en, i_is_load, i_wb_rdt_en;
    logic [31:0] o_op0, o_op1;
    logic [3:0]  o_opcode;
    logic        o_bubble, o_rdt_en, o_stall_up;
    logic [4:0]  o_rdt_addr;

    int pass_cnt = 0;
    int total_cnt = 0;

    alu_issue #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .aresetn(aresetn), .i_stall(i_stall), .i_bubble(i_bubble),
        .i_opcode(i_opcode), .i_rs0_addr(i_rs0_addr), .i_rs1_addr(i_rs1_addr),
        .i_rs0_data(i_rs0_data), .i_rs1_data(i_rs1_data), .i_pc(i_pc), .i_imm(i_imm),
        .i_op0_sel(i_op0_sel), .i_op1_sel(i_op1_sel), .i_rdt_addr(i_rdt_addr),
        .i_rdt_en(i_rdt_en), .i_is_load(i_is_load), .i_exu_data(i_exu_data),
        .i_wb_rdt_addr(i_wb_rdt_addr), .i_wb_rdt_en(i_wb_rdt_en), .i_wb_data(i_wb_data),
        .o_op0(o_op0), .o_op1(o_op1), .o_opcode(o_opcode), .o_bubble(o_bubble),
        .o_rdt_addr(o_rdt_addr), .o_rdt_en(o_rdt_en), .o_stall_up(o_stall_up)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input logic [3:0] op, input logic [1:0] s0, input logic s1,
                        input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] rd, input logic rden, input logic ld);
        i_bubble   = 1'b0;
        i_opcode   = op;
        i_op0_sel  = s0;
        i_op1_sel  = s1;
        i_rs0_addr = a0;
        i_rs0_data = d0;
        i_rs1_addr = a1;
        i_rs1_data = d1;
        i_rdt_addr = rd;
        i_rdt_en   = rden;
        i_is_load  = ld;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        i_wb_rdt_en   = en;
        i_wb_rdt_addr = a;
        i_wb_data     = d;
    endtask

    initial begin
        aresetn = 1'b0;
        i_stall = 1'b0;
        i_pc = 32'h0; i_imm = 32'h0; i_exu_data = 32'h0;
        slot(ALU_ADD, OP0_RS0, OP1_RS1, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0);
        i_bubble = 1'b1;
        wb(1'b0, 5'd0, 32'h0);
        #12;
        check("rst_bubble", {31'b0, o_bubble}, 32'd1);
        check("rst_op0", o_op0, 32'h0);
        check("rst_rdt_en", {31'b0, o_rdt_en}, 32'd0);
        check("rst_stall_up", {31'b0, o_stall_up}, 32'd0);
        @(negedge clk);
        aresetn = 1'b1;

        // Plain ADD x3 = x1 + x2
        slot(ALU_ADD, OP0_RS0, OP1_RS1, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 1'b1, 1'b0);
        tick();
        check("add_op0", o_op0, 32'd5);
        check("add_op1", o_op1, 32'd7);
        check("add_opcode", {28'b0, o_opcode}, {28'b0, ALU_ADD});
        check("add_bubble", {31'b0, o_bubble}, 32'd0);
        check("add_rdt", {27'b0, o_rdt_addr}, 32'd3);
        check("add_rdt_en", {31'b0, o_rdt_en}, 32'd1);

        // EXU forward beats WB forward
        slot(ALU_SUB, OP0_RS0, OP1_RS1, 5'd1, 32'd1, 5'd2, 32'd2, 5'd5, 1'b1, 1'b0);
        tick();
        slot(ALU_OR, OP0_RS0, OP1_RS1, 5'd5, 32'hDEAD, 5'd2, 32'd7, 5'd8, 1'b1, 1'b0);
        i_exu_data = 32'h10;
        wb(1'b1, 5'd5, 32'h99);
        tick();
        check("exu_fwd_op0", o_op0, 32'h10);
        check("exu_fwd_op1", o_op1, 32'd7);
        check("exu_fwd_opcode", {28'b0, o_opcode}, {28'b0, ALU_OR});

        // WB forward on rs1 (EX holds x8, not x9)
        slot(ALU_AND, OP0_PC, OP1_RS1, 5'd0, 32'h0, 5'd9, 32'h1, 5'd10, 1'b1, 1'b0);
        i_pc = 32'h100;
        wb(1'b1, 5'd9, 32'h55);
        tick();
        check("wb_fwd_op1", o_op1, 32'h55);
        check("pc_sel_op0", o_op0, 32'h100);
        wb(1'b0, 5'd0, 32'h0);

        // Load-use: LW x6 then ADDI using x6
        slot(ALU_ADD, OP0_RS0, OP1_IMM, 5'd1, 32'h40, 5'd0, 32'h0, 5'd6, 1'b1, 1'b1);
        tick();
        slot(ALU_ADD, OP0_RS0, OP1_IMM, 5'd6, 32'hBAD, 5'd0, 32'h0, 5'd7, 1'b1, 1'b0);
        i_imm = 32'd4;
        i_exu_data = 32'hEEEE;
        #1;
        check("lu_stall_up", {31'b0, o_stall_up}, 32'd1);
        tick();
        check("lu_bubble", {31'b0, o_bubble}, 32'd1);
        check("lu_rdt_en", {31'b0, o_rdt_en}, 32'd0);
        check("hold_stall_up", {31'b0, o_stall_up}, 32'd0);
        wb(1'b1, 5'd6, 32'h1234);
        tick();
        check("lu_op0", o_op0, 32'h1234);
        check("lu_op1", o_op1, 32'd4);
        check("lu_reissue_bubble", {31'b0, o_bubble}, 32'd0);
        check("lu_reissue_stall", {31'b0, o_stall_up}, 32'd0);
        wb(1'b0, 5'd0, 32'h0);

        // x0 never forwards
        slot(ALU_ADD, OP0_RS0, OP1_RS1, 5'd1, 32'd1, 5'd2, 32'd2, 5'd0, 1'b1, 1'b0);
        tick();
        slot(ALU_ADD, OP0_RS0, OP1_IMM, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0, 5'd4, 1'b1, 1'b0);
        i_exu_data = 32'hFFFF_FFFF;
        wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        check("x0_op0", o_op0, 32'h0);
        wb(1'b0, 5'd0, 32'h0);

        // op0 select code 3 is a bubble
        slot(ALU_ADD, 2'd3, OP1_IMM, 5'd1, 32'd9, 5'd0, 32'h0, 5'd4, 1'b1, 1'b0);
        tick();
        check("sel3_bubble", {31'b0, o_bubble}, 32'd1);
        check("sel3_rdt_en", {31'b0, o_rdt_en}, 32'd0);
        check("sel3_op0", o_op0, 32'h0);

        // ID bubble clears write enable
        slot(ALU_XOR, OP0_ZERO, OP1_IMM, 5'd0, 32'h0, 5'd0, 32'h0, 5'd11, 1'b1, 1'b0);
        i_bubble = 1'b1;
        tick();
        check("idb_bubble", {31'b0, o_bubble}, 32'd1);
        check("idb_rdt_en", {31'b0, o_rdt_en}, 32'd0);

        // Downstream stall holds outputs for three cycles
        slot(ALU_XOR, OP0_RS0, OP1_RS1, 5'd12, 32'h11, 5'd13, 32'h22, 5'd14, 1'b1, 1'b0);
        tick();
        check("pre_stall_op0", o_op0, 32'h11);
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            slot(ALU_SLL, OP0_RS0, OP1_RS1, 5'd15, 32'h33 + k, 5'd16, 32'h44, 5'd17, 1'b1, 1'b0);
            #1;
            check("stall_up", {31'b0, o_stall_up}, 32'd1);
            tick();
            check("stall_hold_op0", o_op0, 32'h11);
            check("stall_hold_opcode", {28'b0, o_opcode}, {28'b0, ALU_XOR});
            check("stall_hold_rdt", {27'b0, o_rdt_addr}, 32'd14);
        end
        i_stall = 1'b0;
        tick();
        check("unstall_op0", o_op0, 32'h35);
        check("unstall_op1", o_op1, 32'h44);
        check("unstall_rdt", {27'b0, o_rdt_addr}, 32'd17);

        // Reset while in HOLD
        slot(ALU_ADD, OP0_RS0, OP1_IMM, 5'd1, 32'h0, 5'd0, 32'h0, 5'd6, 1'b1, 1'b1);
        tick();
        slot(ALU_ADD, OP0_RS0, OP1_RS1, 5'd6, 32'h77, 5'd2, 32'h8, 5'd7, 1'b1, 1'b0);
        tick();
        check("hold_entry_bubble", {31'b0, o_bubble}, 32'd1);
        #2;
        aresetn = 1'b0;
        #1;
        check("hrst_bubble", {31'b0, o_bubble}, 32'd1);
        check("hrst_op0", o_op0, 32'h0);
        check("hrst_rdt", {27'b0, o_rdt_addr}, 32'd0);
        check("hrst_stall_up", {31'b0, o_stall_up}, 32'd0);
        @(negedge clk);
        aresetn = 1'b1;
        #1;
        check("post_rst_stall_up", {31'b0, o_stall_up}, 32'd0);
        tick();
        check("post_rst_op0", o_op0, 32'h77);
        check("post_rst_bubble", {31'b0, o_bubble}, 32'd0);
        check("post_rst_rdt", {27'b0, o_rdt_addr}, 32'd7);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
